// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the ID-stage hazard logic.
// Holds the stall FSM state encoding and the default widths, so the
// forwarding and control units decode the same values.
package hazard_stall_controller_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF      = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hsc_state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle between the ID-stage decode/comparator and the hazard stall controller.
//   master : ID-stage side; drives the decoded operand/branch fields and
//            the EX-stage destination info, and receives the write enables,
//            bubble, flush and the performance counters.
//   slave  : the hazard stall controller.
interface hazard_stall_controller_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] IFIDrs;
  logic [REG_ADDR_W-1:0] IFIDrt;
  logic                  IFIDUsesRt;
  logic                  IFIDbeq;
  logic                  IFIDbne;
  logic                  IFIDjump;
  logic                  BranchTaken;
  logic [REG_ADDR_W-1:0] IDEXRegisterRd;
  logic                  IDEXRegWrite;
  logic                  IDEXMemRead;
  logic                  PCWrite;
  logic                  IFIDWrite;
  logic                  IDEXBubble;
  logic                  IFIDFlush;
  logic [CNT_W-1:0]      StallCycles;
  logic [CNT_W-1:0]      FlushCount;

  modport master (
    output IFIDrs, IFIDrt, IFIDUsesRt, IFIDbeq, IFIDbne, IFIDjump, BranchTaken,
           IDEXRegisterRd, IDEXRegWrite, IDEXMemRead,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallCycles, FlushCount
  );

  modport slave (
    input  IFIDrs, IFIDrt, IFIDUsesRt, IFIDbeq, IFIDbne, IFIDjump, BranchTaken,
           IDEXRegisterRd, IDEXRegWrite, IDEXMemRead,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter for the performance report.
//   clk_i   : clock, rising edge
//   clear_i : synchronous clear (wins over inc_i)
//   inc_i   : count one event this cycle
//   count_o : current count, holds at all-ones
module hazard_stall_controller_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Hazard stall controller for the 5-stage MIPS pipeline.
// Detects the hazards forwarding cannot cover (load-use, branch-after-ALU,
// branch-after-load), stalls PC and IF/ID while bubbling ID/EX, and flushes
// IF/ID on a taken branch or jump once the branch is allowed to proceed.
//   clk   : pipeline clock, rising edge
//   reset : synchronous, active-high
//   hz    : slave side of hazard_stall_controller_if (decode fields in,
//           write enables / bubble / flush / performance counters out)
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_stall_controller_if.slave hz
);

  hsc_state_t state_q, state_d;

  logic [REG_ADDR_W-1:0] rd, rs, rt;
  logic match_rs, match_rt, br;
  logic lu, ba, bl;
  logic stall, flush;

  assign rd = hz.IDEXRegisterRd;
  assign rs = hz.IFIDrs;
  assign rt = hz.IFIDrt;

  always_comb begin
    // $0 is never a real producer, so it never creates a dependency.
    match_rs = (rd != '0) && (rd == rs);
    match_rt = (rd != '0) && (rd == rt) && hz.IFIDUsesRt;
    br       = hz.IFIDbeq || hz.IFIDbne;
    lu       = hz.IDEXMemRead && (match_rs || match_rt) && !br;
    ba       = br && hz.IDEXRegWrite && !hz.IDEXMemRead && (match_rs || match_rt);
    bl       = br && hz.IDEXMemRead && (match_rs || match_rt);

    stall   = 1'b0;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        stall = lu || ba || bl;
        if (bl) state_d = HOLD;
      end
      // Second cycle of branch-after-load: the load is in MEM, inputs ignored.
      HOLD: begin
        stall   = 1'b1;
        state_d = RUN;
      end
      default: begin
        stall   = 1'b0;
        state_d = RUN;
      end
    endcase

    // Stall beats flush so a stalled taken branch flushes exactly once.
    flush = !stall && ((hz.BranchTaken && br) || hz.IFIDjump);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign hz.PCWrite    = !stall;
  assign hz.IFIDWrite  = !stall;
  assign hz.IDEXBubble = stall;
  assign hz.IFIDFlush  = flush;

  hazard_stall_controller_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .clear_i (reset),
    .inc_i   (stall),
    .count_o (hz.StallCycles)
  );

  hazard_stall_controller_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk),
    .clear_i (reset),
    .inc_i   (flush),
    .count_o (hz.FlushCount)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(16)) hz  ();
  hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(4))  hz4 ();

  hazard_stall_controller #(.CNT_W(16), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  hazard_stall_controller #(.CNT_W(4), .REG_ADDR_W(5)) dut4 (
    .clk   (clk),
    .reset (reset),
    .hz    (hz4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic clr_inputs();
    hz.IFIDrs = '0; hz.IFIDrt = '0; hz.IFIDUsesRt = 1'b0;
    hz.IFIDbeq = 1'b0; hz.IFIDbne = 1'b0; hz.IFIDjump = 1'b0; hz.BranchTaken = 1'b0;
    hz.IDEXRegisterRd = '0; hz.IDEXRegWrite = 1'b0; hz.IDEXMemRead = 1'b0;
    hz4.IFIDrs = '0; hz4.IFIDrt = '0; hz4.IFIDUsesRt = 1'b0;
    hz4.IFIDbeq = 1'b0; hz4.IFIDbne = 1'b0; hz4.IFIDjump = 1'b0; hz4.BranchTaken = 1'b0;
    hz4.IDEXRegisterRd = '0; hz4.IDEXRegWrite = 1'b0; hz4.IDEXMemRead = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clr_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    checks++;
    if ({hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble, hz.IFIDFlush} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 1100", {hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble, hz.IFIDFlush});
    end
    checks++;
    if (hz.StallCycles !== 16'd0 || hz.FlushCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d required 0/0", hz.StallCycles, hz.FlushCount);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    // lw $2 in EX; add $3,$2,$4 in ID
    @(negedge clk);
    hz.IDEXMemRead = 1'b1; hz.IDEXRegWrite = 1'b1; hz.IDEXRegisterRd = 5'd2;
    hz.IFIDrs = 5'd2; hz.IFIDrt = 5'd4; hz.IFIDUsesRt = 1'b1;
    #1;
    checks++;
    if ({hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble} !== 3'b001) begin
      errors++;
      $display("FAIL lu_stall: got %b required 001", {hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble});
    end
    @(negedge clk);
    hz.IDEXMemRead = 1'b0; hz.IDEXRegWrite = 1'b0; hz.IDEXRegisterRd = 5'd0;
    #1;
    checks++;
    if ({hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble} !== 3'b110) begin
      errors++;
      $display("FAIL lu_release: got %b required 110", {hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble});
    end
    checks++;
    if (hz.StallCycles !== 16'd1) begin
      errors++;
      $display("FAIL lu_count: got %0d required 1", hz.StallCycles);
    end
    // rt match stalls only when rt is a source
    @(negedge clk);
    hz.IDEXMemRead = 1'b1; hz.IDEXRegisterRd = 5'd4;
    hz.IFIDrs = 5'd9; hz.IFIDrt = 5'd4; hz.IFIDUsesRt = 1'b1;
    #1;
    checks++;
    if (hz.IDEXBubble !== 1'b1) begin
      errors++;
      $display("FAIL lu_rt_match: got %b required 1", hz.IDEXBubble);
    end
    @(negedge clk);
    hz.IFIDUsesRt = 1'b0;
    #1;
    checks++;
    if (hz.IDEXBubble !== 1'b0) begin
      errors++;
      $display("FAIL lu_rt_unused: got %b required 0", hz.IDEXBubble);
    end
  endtask

  task automatic test_branch_alu();
    do_reset();
    // add $5 in EX; beq $5,$6 in ID, not taken
    @(negedge clk);
    hz.IDEXRegWrite = 1'b1; hz.IDEXRegisterRd = 5'd5;
    hz.IFIDbeq = 1'b1; hz.IFIDrs = 5'd5; hz.IFIDrt = 5'd6; hz.IFIDUsesRt = 1'b1;
    #1;
    checks++;
    if ({hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush} !== 3'b010) begin
      errors++;
      $display("FAIL ba_stall: got %b required 010", {hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush});
    end
    @(negedge clk);
    hz.IDEXRegWrite = 1'b0; hz.IDEXRegisterRd = 5'd0;
    #1;
    // one cycle only: FSM stayed in RUN
    checks++;
    if ({hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush} !== 3'b100) begin
      errors++;
      $display("FAIL ba_release: got %b required 100", {hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush});
    end
    checks++;
    if (hz.StallCycles !== 16'd1) begin
      errors++;
      $display("FAIL ba_count: got %0d required 1", hz.StallCycles);
    end
  endtask

  task automatic test_branch_load();
    do_reset();
    // lw $7 in EX; bne $7,$0 in ID, taken
    @(negedge clk);
    hz.IDEXMemRead = 1'b1; hz.IDEXRegWrite = 1'b1; hz.IDEXRegisterRd = 5'd7;
    hz.IFIDbne = 1'b1; hz.IFIDrs = 5'd7; hz.IFIDrt = 5'd0; hz.IFIDUsesRt = 1'b1;
    hz.BranchTaken = 1'b1;
    #1;
    checks++;
    if ({hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush} !== 3'b010) begin
      errors++;
      $display("FAIL bl_cycle1: got %b required 010", {hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush});
    end
    // EX now holds the bubble: the stall comes from HOLD alone
    @(negedge clk);
    hz.IDEXMemRead = 1'b0; hz.IDEXRegWrite = 1'b0; hz.IDEXRegisterRd = 5'd0;
    #1;
    checks++;
    if ({hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush} !== 3'b010) begin
      errors++;
      $display("FAIL bl_cycle2: got %b required 010", {hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush});
    end
    @(negedge clk); #1;
    checks++;
    if ({hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush} !== 3'b101) begin
      errors++;
      $display("FAIL bl_cycle3: got %b required 101", {hz.PCWrite, hz.IDEXBubble, hz.IFIDFlush});
    end
    @(negedge clk);
    clr_inputs();
    #1;
    checks++;
    if (hz.StallCycles !== 16'd2 || hz.FlushCount !== 16'd1) begin
      errors++;
      $display("FAIL bl_counts: got %0d/%0d required 2/1", hz.StallCycles, hz.FlushCount);
    end
  endtask

  task automatic test_reg_zero_and_jump();
    do_reset();
    @(negedge clk);
    hz.IDEXMemRead = 1'b1; hz.IDEXRegWrite = 1'b1; hz.IDEXRegisterRd = 5'd0;
    hz.IFIDrs = 5'd0; hz.IFIDrt = 5'd0; hz.IFIDUsesRt = 1'b1;
    #1;
    checks++;
    if ({hz.PCWrite, hz.IDEXBubble} !== 2'b10) begin
      errors++;
      $display("FAIL reg0_no_stall: got %b required 10", {hz.PCWrite, hz.IDEXBubble});
    end
    @(negedge clk);
    clr_inputs();
    hz.IFIDjump = 1'b1;
    #1;
    checks++;
    if ({hz.PCWrite, hz.IFIDFlush} !== 2'b11) begin
      errors++;
      $display("FAIL jump_flush: got %b required 11", {hz.PCWrite, hz.IFIDFlush});
    end
    @(negedge clk);
    clr_inputs();
    hz.IFIDbeq = 1'b1; hz.BranchTaken = 1'b1; hz.IFIDrs = 5'd3;
    #1;
    checks++;
    if (hz.IFIDFlush !== 1'b1) begin
      errors++;
      $display("FAIL taken_beq_flush: got %b required 1", hz.IFIDFlush);
    end
    @(negedge clk);
    clr_inputs();
    hz.BranchTaken = 1'b1;
    #1;
    checks++;
    if (hz.IFIDFlush !== 1'b0) begin
      errors++;
      $display("FAIL taken_no_branch: got %b required 0", hz.IFIDFlush);
    end
    checks++;
    if (hz.FlushCount !== 16'd2 || hz.StallCycles !== 16'd0) begin
      errors++;
      $display("FAIL flush_count: got %0d/%0d required 2/0", hz.FlushCount, hz.StallCycles);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    @(negedge clk);
    hz.IDEXMemRead = 1'b1; hz.IDEXRegisterRd = 5'd7;
    hz.IFIDbeq = 1'b1; hz.IFIDrs = 5'd7;
    #1;
    checks++;
    if (hz.IDEXBubble !== 1'b1) begin
      errors++;
      $display("FAIL hold_entry: got %b required 1", hz.IDEXBubble);
    end
    @(negedge clk);
    reset = 1'b1;
    clr_inputs();
    #1;
    checks++;
    if (hz.PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL hold_before_reset: got %b required 0", hz.PCWrite);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble} !== 3'b110) begin
      errors++;
      $display("FAIL hold_reset_outputs: got %b required 110", {hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble});
    end
    checks++;
    if (hz.StallCycles !== 16'd0 || hz.FlushCount !== 16'd0) begin
      errors++;
      $display("FAIL hold_reset_counters: got %0d/%0d required 0/0", hz.StallCycles, hz.FlushCount);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    // continuous load-use on the 4-bit build: 19 stalled cycles
    @(negedge clk);
    hz4.IDEXMemRead = 1'b1; hz4.IDEXRegisterRd = 5'd2; hz4.IFIDrs = 5'd2;
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (hz4.StallCycles !== 4'd14) begin
      errors++;
      $display("FAIL sat_14: got %0d required 14", hz4.StallCycles);
    end
    @(posedge clk); #1;
    checks++;
    if (hz4.StallCycles !== 4'hF) begin
      errors++;
      $display("FAIL sat_15: got %0d required 15", hz4.StallCycles);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (hz4.StallCycles !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold: got %0d required 15", hz4.StallCycles);
    end
    clr_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clr_inputs();
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_reg_zero_and_jump();
    test_reset_in_hold();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
